// File: rtl/popcount_stream_if.sv
// popcount_stream_if: stream bundle for popcount_stream.
// Carries the word input stream (valid/ready/data/last/zeros) and the frame
// total output stream (valid/ready/count/sat). When POPCOUNT_STREAM_THRESH_EN
// is defined, it also carries the threshold input and the above-threshold flag.
// The slave modport is the block's view. The master modport is the
// source/consumer view.
interface popcount_stream_if #(
    parameter int WL    = 32,
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WL-1:0]    in_data;
    logic             in_last;
    logic             in_zeros;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_count;
    logic             out_sat;
`ifdef POPCOUNT_STREAM_THRESH_EN
    logic [ACC_W-1:0] thresh;
    logic             out_above;
`endif

    modport slave (
        input  in_valid, in_data, in_last, in_zeros, out_ready,
        output in_ready, out_valid, out_count, out_sat
`ifdef POPCOUNT_STREAM_THRESH_EN
        , input thresh
        , output out_above
`endif
    );

    modport master (
        output in_valid, in_data, in_last, in_zeros, out_ready,
        input  in_ready, out_valid, out_count, out_sat
`ifdef POPCOUNT_STREAM_THRESH_EN
        , output thresh
        , input out_above
`endif
    );
endinterface

// File: rtl/popcount_stream.sv
// popcount_stream: handshaked, chunked population counter.
// Each accepted WL-bit word is shadowed and scanned CHUNK bits per clock.
// Counts accumulate over a frame that ends on the word with in_last set.
// The block then presents one saturating total per frame.
// The first word of a frame selects the mode: count ones, or count zeros.
// Optional feature macro: POPCOUNT_STREAM_THRESH_EN adds the thresh input and
// the out_above flag.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The source holds data while valid=1 and ready=0. in_ready and
// out_valid are decoded from registered state only, so there is no
// combinational path from in_valid or out_ready back to them.
module popcount_stream #(
    parameter int WL    = 32,
    parameter int CHUNK = 8,
    parameter int ACC_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    popcount_stream_if.slave    bus,
    output logic [1:0]          dbg_state
);
    localparam int N  = WL / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(CHUNK + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state;
    logic [WL-1:0]    shadow;
    logic             last_q;
    logic             mode;
    logic             frame_start;
    logic [IW-1:0]    idx;
    logic [ACC_W-1:0] acc;
    logic             sat;

    logic [CHUNK-1:0] chunk;
    logic [CW-1:0]    cnt;
    logic [ACC_W:0]   sum;
    logic             sat_hit;
    logic [ACC_W-1:0] acc_next;

`ifdef POPCOUNT_STREAM_THRESH_EN
    logic             above;
`endif

    // Count the current chunk of the shadow word. The chunk is inverted in
    // zeros mode. The add to the accumulator clamps at all-ones.
    always_comb begin
        chunk = shadow[int'(idx) * CHUNK +: CHUNK] ^ {CHUNK{mode}};
        cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cnt = cnt + CW'(chunk[i]);
        end
        sum      = {1'b0, acc} + (ACC_W + 1)'(cnt);
        sat_hit  = sum[ACC_W];
        acc_next = sat_hit ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

    // Control FSM. It performs word capture, the chunk scan with
    // accumulation, and holding the frame total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= '0;
            last_q      <= 1'b0;
            mode        <= 1'b0;
            frame_start <= 1'b1;
            idx         <= '0;
            acc         <= '0;
            sat         <= 1'b0;
`ifdef POPCOUNT_STREAM_THRESH_EN
            above       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shadow <= bus.in_data;
                        last_q <= bus.in_last;
                        idx    <= '0;
                        state  <= SCAN;
                        // Mode and the running total belong to the frame,
                        // so they are only touched on its first word.
                        if (frame_start) begin
                            mode        <= bus.in_zeros;
                            acc         <= '0;
                            sat         <= 1'b0;
                            frame_start <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    acc <= acc_next;
                    if (sat_hit) begin
                        sat <= 1'b1;
                    end
                    if (idx == IW'(N - 1)) begin
                        if (last_q) begin
                            state <= OUT;
`ifdef POPCOUNT_STREAM_THRESH_EN
                            above <= (acc_next >= bus.thresh);
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        frame_start <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode. Every output is taken from registered state.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == OUT);
        bus.out_count = acc;
        bus.out_sat   = sat;
        dbg_state     = state;
`ifdef POPCOUNT_STREAM_THRESH_EN
        bus.out_above = above;
`endif
    end
endmodule

// File: tb/tb_popcount_stream.sv
// tb_popcount_stream: directed bench for popcount_stream.
// Two instances are driven through one shared set of driver signals:
// - dut_a uses the default parameters.
// - dut_b uses ACC_W=6 for the saturation case.
// sel picks which instance the driver tasks talk to.
module tb_popcount_stream;
    logic clk;
    logic rst;

    popcount_stream_if #(.WL(32), .ACC_W(16)) bus_a ();
    popcount_stream_if #(.WL(32), .ACC_W(6))  bus_b ();
    logic [1:0] dbg_a;
    logic [1:0] dbg_b;

    popcount_stream #(.WL(32), .CHUNK(8), .ACC_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .dbg_state(dbg_a)
    );
    popcount_stream #(.WL(32), .CHUNK(8), .ACC_W(6)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .dbg_state(dbg_b)
    );

    // Driver signals, routed to the instance chosen by sel.
    logic        sel;
    logic        drv_valid;
    logic [31:0] drv_data;
    logic        drv_last;
    logic        drv_zeros;
    logic        drv_ordy;
    logic [15:0] drv_thresh;

    assign bus_a.in_valid  = drv_valid & ~sel;
    assign bus_b.in_valid  = drv_valid & sel;
    assign bus_a.in_data   = drv_data;
    assign bus_b.in_data   = drv_data;
    assign bus_a.in_last   = drv_last;
    assign bus_b.in_last   = drv_last;
    assign bus_a.in_zeros  = drv_zeros;
    assign bus_b.in_zeros  = drv_zeros;
    assign bus_a.out_ready = drv_ordy & ~sel;
    assign bus_b.out_ready = drv_ordy & sel;
`ifdef POPCOUNT_STREAM_THRESH_EN
    assign bus_a.thresh    = drv_thresh;
    assign bus_b.thresh    = drv_thresh[5:0];
`endif

    logic        obs_ready;
    logic        obs_ovalid;
    logic [15:0] obs_count;
    logic        obs_sat;
    assign obs_ready  = sel ? bus_b.in_ready  : bus_a.in_ready;
    assign obs_ovalid = sel ? bus_b.out_valid : bus_a.out_valid;
    assign obs_count  = sel ? {10'd0, bus_b.out_count} : bus_a.out_count;
    assign obs_sat    = sel ? bus_b.out_sat   : bus_a.out_sat;

    // Scoreboard entry: {above, sat, count[15:0]}.
    logic [17:0] exp_q[$];
    int n_checks;
    int n_fail;

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one word and wait for it to be taken. For a non-last word,
    // chk_gap also measures how many cycles pass before in_ready returns.
    task automatic send(input logic [31:0] d, input logic last, input logic z, input bit chk_gap);
        int n;
        n = 0;
        while (!obs_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_send", 32'(obs_ready), 32'd1);
        drv_valid = 1'b1;
        drv_data  = d;
        drv_last  = last;
        drv_zeros = z;
        @(negedge clk);
        drv_valid = 1'b0;
        drv_data  = $urandom;
        if (chk_gap && !last) begin
            n = 1;
            while (!obs_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("reaccept_gap", 32'(n), 32'd5);
        end
    endtask

    // Wait for a frame total and compare it with the scoreboard head.
    // The total can be held back for 'stall' cycles before it is accepted.
    task automatic recv(input int stall);
        int n;
        logic [17:0] exp;
        n = 0;
        while (!obs_ovalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_wait", 32'(obs_ovalid), 32'd1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: observed output, expected none");
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        check("out_count", 32'(obs_count), 32'(exp[15:0]));
        check("out_sat", 32'(obs_sat), 32'(exp[16]));
`ifdef POPCOUNT_STREAM_THRESH_EN
        if (!sel) check("out_above", 32'(bus_a.out_above), 32'(exp[17]));
`endif
        for (int i = 0; i < stall; i++) begin
            drv_valid = 1'b1;
            drv_data  = 32'hFFFF_FFFF;
            drv_last  = 1'b1;
            @(negedge clk);
            check("stall_in_ready", 32'(obs_ready), 32'd0);
            check("stall_count", 32'(obs_count), 32'(exp[15:0]));
        end
        drv_valid = 1'b0;
        drv_ordy  = 1'b1;
        @(negedge clk);
        drv_ordy  = 1'b0;
        check("ready_after_hs", 32'(obs_ready), 32'd1);
        check("valid_after_hs", 32'(obs_ovalid), 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        sel        = 1'b0;
        drv_valid  = 1'b0;
        drv_data   = '0;
        drv_last   = 1'b0;
        drv_zeros  = 1'b0;
        drv_ordy   = 1'b0;
        drv_thresh = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(obs_ready), 32'd1);
        check("rst_out_valid", 32'(obs_ovalid), 32'd0);
        check("rst_out_count", 32'(obs_count), 32'd0);
        check("rst_out_sat", 32'(obs_sat), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single full word with exact latency: 4 scan cycles, then the total.
        exp_q.push_back({1'b1, 1'b0, 16'd32});
        drv_valid = 1'b1;
        drv_data  = 32'hFFFF_FFFF;
        drv_last  = 1'b1;
        drv_zeros = 1'b0;
        @(negedge clk);
        drv_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("scan_in_ready", 32'(obs_ready), 32'd0);
            check("scan_out_valid", 32'(obs_ovalid), 32'd0);
            @(negedge clk);
        end
        check("out_valid_at_T5", 32'(obs_ovalid), 32'd1);
        recv(0);

        // Three-word frame, counting ones.
        exp_q.push_back({1'b1, 1'b0, 16'd18});
        send(32'h0F0F_0F0F, 1'b0, 1'b0, 1'b1);
        send(32'h0000_0001, 1'b0, 1'b0, 1'b1);
        send(32'h8000_0000, 1'b1, 1'b0, 1'b0);
        recv(0);

        // Zeros mode, then ones mode. Then in_zeros is toggled on a
        // non-first word, which must have no effect.
        exp_q.push_back({1'b1, 1'b0, 16'd24});
        send(32'h0000_00FF, 1'b1, 1'b1, 1'b0);
        recv(0);
        exp_q.push_back({1'b1, 1'b0, 16'd8});
        send(32'h0000_00FF, 1'b1, 1'b0, 1'b0);
        recv(0);
        exp_q.push_back({1'b1, 1'b0, 16'd16});
        send(32'h0000_00FF, 1'b0, 1'b0, 1'b1);
        send(32'h0000_00FF, 1'b1, 1'b1, 1'b0);
        recv(0);

        // Backpressure: the total is held for 10 cycles while in_valid is
        // offered. The offered input must be ignored.
        exp_q.push_back({1'b1, 1'b0, 16'd16});
        send(32'h00FF_00FF, 1'b1, 1'b0, 1'b0);
        recv(10);
        exp_q.push_back({1'b1, 1'b0, 16'd3});
        send(32'h0000_0007, 1'b1, 1'b0, 1'b0);
        recv(0);

        // Saturation on the 6-bit instance, then recovery on the next frame.
        sel = 1'b1;
        @(negedge clk);
        exp_q.push_back({1'b0, 1'b1, 16'd63});
        send(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        recv(0);
        exp_q.push_back({1'b0, 1'b0, 16'd2});
        send(32'h0000_0003, 1'b1, 1'b0, 1'b0);
        recv(0);
        sel = 1'b0;
        @(negedge clk);

        // Reset pulse during the second scan cycle aborts the frame.
        send(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(obs_ready), 32'd1);
        check("abort_out_valid", 32'(obs_ovalid), 32'd0);
        check("abort_out_count", 32'(obs_count), 32'd0);
        check("abort_out_sat", 32'(obs_sat), 32'd0);
`ifdef POPCOUNT_STREAM_THRESH_EN
        check("abort_out_above", 32'(bus_a.out_above), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drv_thresh = 16'd1;
        exp_q.push_back({1'b1, 1'b0, 16'd1});
        send(32'h0000_0001, 1'b1, 1'b0, 1'b0);
        recv(0);
        drv_thresh = 16'd2;
        exp_q.push_back({1'b0, 1'b0, 16'd1});
        send(32'h0000_0001, 1'b1, 1'b0, 1'b0);
        recv(0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/popcount_stream.md
# popcount_stream

Sequential, handshaked population counter: the parametrised successor to the combinational one-word bit counter. It accepts WL-bit words over a valid/ready stream and counts CHUNK bits per clock. It accumulates counts across every word of a frame terminated by `in_last`, then presents one saturating total per frame. It sits between a bit-vector source (bitmap, error-flag or mask stream) and consumers that need per-frame ones/zeros totals without a WL-wide adder tree.

## Interface
- `WL`, 32, input word width in bits; must be a multiple of CHUNK.
- `CHUNK`, 8, bits counted per clock; N = WL/CHUNK scan cycles per word.
- `ACC_W`, 16, accumulator/result width; must satisfy ACC_W >= $clog2(WL+1).
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  WL  word to count.
- `in_last`  in  1  word is the final word of the frame.
- `in_zeros`  in  1  frame mode: 0 counts ones, 1 counts zeros; sampled on the first word of a frame only.
- `out_valid`  out  1  frame total valid.
- `out_ready`  in  1  consumer accepts the total.
- `out_count`  out  ACC_W  frame total.
- `out_sat`  out  1  total saturated during the frame.

## Operation
- Reset: state IDLE; accumulator, word shadow, chunk index, `out_count`, `out_sat` and `out_valid` are 0. Frame-start flag = 1. `in_ready` = 1, because it is decoded from state.
- States:
  - IDLE (`in_ready`=1):
    - On `in_valid`, capture `in_data`, `in_last` and the chunk index (= 0), then go to SCAN.
    - If frame-start flag = 1, also latch `in_zeros` into the mode register, clear the accumulator and `out_sat`, then clear frame-start.
  - SCAN: each cycle, popcount chunk `[idx*CHUNK +: CHUNK]` of the shadow word, inverted when mode = zeros. Add the chunk count ($clog2(CHUNK+1) bits, zero-extended) to the accumulator.
    - After chunk N-1: if the captured last = 1, go to OUT; otherwise return to IDLE.
  - OUT (`out_valid`=1): `out_count` and `out_sat` are held stable. On `out_ready`, go to IDLE and set frame-start = 1.
- Arithmetic: the accumulator saturates at 2^ACC_W-1. Any add that would exceed it clamps to 2^ACC_W-1 and sets `out_sat`, which is sticky until the next frame start.
- `out_count` is the registered accumulator value. It is meaningful only while `out_valid`=1.
- `in_ready` and `out_valid` are never both 1. No input is accepted while a total is pending.
- `in_data` changes while `in_ready`=0 are ignored, because the word is shadowed.
- A single-word frame (`in_last`=1 on the first word) is legal.
- Reset asserted in any state aborts the frame. The partial count is discarded and the block returns to the reset state.

## Timing
- Word accepted at rising edge T. Chunk adds occur at edges T+1 … T+N.
- Non-last word: `in_ready`=1 again from cycle T+N+1.
- Last word: `out_valid`=1 from cycle T+N+1.
- Handshake at edge U (`out_valid` & `out_ready`): `in_ready`=1 from cycle U+1.
- Throughput: one word per N+1 cycles, plus at least 1 cycle per frame for output.
- Standard valid/ready rules:
  - The source must hold `in_data`/`in_last`/`in_zeros` while `in_valid`=1 and `in_ready`=0.
  - The block holds `out_count`/`out_sat` while `out_valid`=1 and `out_ready`=0.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Configuration
- `POPCOUNT_STREAM_THRESH_EN` defined:
  - Adds input `thresh` [ACC_W] and output `out_above` [1].
  - `out_above` = (final accumulator >= `thresh`). It is registered on the OUT transition, valid with `out_valid`, held stable with `out_count`, and resets to 0.
  - `thresh` is sampled on the last chunk add of the frame.
- Not defined: neither port exists and no compare logic is built. All other behaviour is identical.

## Test plan
Defaults WL=32, CHUNK=8, ACC_W=16 unless stated.
- Single word 0xFFFFFFFF with `in_last`=1, accepted at T -> `out_valid` rises at T+5 with `out_count`=32, `out_sat`=0; `in_ready`=0 during T+1..T+5.
- Three-word frame 0x0F0F0F0F, 0x00000001, 0x80000000 (last on the third), mode ones -> one total of 18. `in_ready` re-asserts 5 cycles after each non-last accept.
- Zeros mode: `in_zeros`=1, single word 0x000000FF -> 24. Next frame with `in_zeros`=0 and the same word -> 8. Toggling `in_zeros` on a non-first word has no effect.
- Saturation with ACC_W=6: frame of three 0xFFFFFFFF words -> `out_count`=63, `out_sat`=1. The following frame 0x00000003 -> 2, `out_sat`=0.
- Backpressure: `out_ready`=0 for 10 cycles while `out_valid`=1 -> `out_count` stable, `in_ready`=0, `in_valid` ignored. Raise `out_ready` -> `in_ready`=1 the next cycle.
- Reset pulse on the 2nd SCAN cycle of a 0xFFFFFFFF word -> all outputs 0 and `in_ready`=1 while reset is asserted. The next frame 0x00000001 (last) -> 1. With `POPCOUNT_STREAM_THRESH_EN`, also check `thresh`=1 -> `out_above`=1, and `thresh`=2 -> `out_above`=0.
